// File: rtl/adder_share_arbiter.sv
// rtl/adder_share_arbiter.sv - round-robin sharing of one recursive-doubling adder among NREQ requesters
//
// Ports:
//   clk, rst              single rising-edge clock, synchronous active-high reset
//   req_valid[NREQ]       per-requester request valid
//   req_a/req_b           packed operands, requester i at [i*WIDTH +: WIDTH]
//   req_ready[NREQ]       one-hot combinational grant, only in IDLE
//   resp_valid/resp_ready result handshake
//   resp_id               requester index of the presented result
//   resp_sum/resp_cout    registered {cout,sum} = a + b
//   busy                  high while an operation is settling or being presented

// Recursive-doubling (Kogge-Stone) adder core, no carry-in. Purely combinational;
// the parent samples it as a multicycle path.
module rd_adder_core #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);
    localparam int LEVELS = $clog2(WIDTH);

    logic [WIDTH-1:0] p0;
    logic [WIDTH-1:0] g_cur;
    logic [WIDTH-1:0] p_cur;
    logic [WIDTH-1:0] g_nxt;
    logic [WIDTH-1:0] p_nxt;

    always_comb begin
        p0    = a ^ b;
        g_cur = a & b;
        p_cur = a ^ b;
        g_nxt = '0;
        p_nxt = '0;
        // Each level doubles the span of the group generate/propagate terms.
        for (int k = 0; k < LEVELS; k++) begin
            g_nxt = g_cur;
            p_nxt = p_cur;
            for (int i = 0; i < WIDTH; i++) begin
                if (i >= (1 << k)) begin
                    g_nxt[i] = g_cur[i] | (p_cur[i] & g_cur[i - (1 << k)]);
                    p_nxt[i] = p_cur[i] & p_cur[i - (1 << k)];
                end
            end
            g_cur = g_nxt;
            p_cur = p_nxt;
        end
        // After the last level g_cur[i] is the carry out of bit i.
        sum  = p0 ^ {g_cur[WIDTH-2:0], 1'b0};
        cout = g_cur[WIDTH-1];
    end
endmodule

module adder_share_arbiter #(
    parameter int NREQ       = 4,
    parameter int WIDTH      = 32,
    parameter int ADD_CYCLES = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NREQ-1:0]          req_valid,
    input  logic [NREQ*WIDTH-1:0]    req_a,
    input  logic [NREQ*WIDTH-1:0]    req_b,
    output logic [NREQ-1:0]          req_ready,
    output logic                     resp_valid,
    input  logic                     resp_ready,
    output logic [$clog2(NREQ)-1:0]  resp_id,
    output logic [WIDTH-1:0]         resp_sum,
    output logic                     resp_cout,
    output logic                     busy
);
    localparam int IDW = $clog2(NREQ);
    localparam int CW  = (ADD_CYCLES > 1) ? $clog2(ADD_CYCLES) : 1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

    state_t           state_q,      state_d;
    logic [CW-1:0]    cnt_q,        cnt_d;
    logic [WIDTH-1:0] op_a_q,       op_a_d;
    logic [WIDTH-1:0] op_b_q,       op_b_d;
    logic [IDW-1:0]   last_grant_q, last_grant_d;
    logic [IDW-1:0]   resp_id_q,    resp_id_d;
    logic [WIDTH-1:0] resp_sum_q,   resp_sum_d;
    logic             resp_cout_q,  resp_cout_d;
    logic             resp_valid_q, resp_valid_d;

    logic [WIDTH-1:0] core_sum;
    logic             core_cout;

    logic             grant_found;
    logic [IDW-1:0]   grant_idx;
    int               scan_idx;

    // Core inputs come only from op_a_q/op_b_q, which are written solely on
    // the accept edge, so they are stable throughout SETTLE and RESP.
    rd_adder_core #(.WIDTH(WIDTH)) u_core (
        .a    (op_a_q),
        .b    (op_b_q),
        .sum  (core_sum),
        .cout (core_cout)
    );

    // Round-robin pick: first valid requester after last_grant, wrapping at NREQ.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        scan_idx    = 0;
        for (int off = 1; off <= NREQ; off++) begin
            scan_idx = (int'(last_grant_q) + off) % NREQ;
            if (!grant_found && req_valid[scan_idx[IDW-1:0]]) begin
                grant_found = 1'b1;
                grant_idx   = scan_idx[IDW-1:0];
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (state_q == ST_IDLE && grant_found) begin
            req_ready[grant_idx] = 1'b1;
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        op_a_d       = op_a_q;
        op_b_d       = op_b_q;
        last_grant_d = last_grant_q;
        resp_id_d    = resp_id_q;
        resp_sum_d   = resp_sum_q;
        resp_cout_d  = resp_cout_q;
        resp_valid_d = resp_valid_q;
        case (state_q)
            ST_IDLE: begin
                if (grant_found) begin
                    op_a_d       = req_a[int'(grant_idx)*WIDTH +: WIDTH];
                    op_b_d       = req_b[int'(grant_idx)*WIDTH +: WIDTH];
                    resp_id_d    = grant_idx;
                    last_grant_d = grant_idx;
                    cnt_d        = CW'(ADD_CYCLES - 1);
                    state_d      = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    resp_sum_d   = core_sum;
                    resp_cout_d  = core_cout;
                    resp_valid_d = 1'b1;
                    state_d      = ST_RESP;
                end
            end
            ST_RESP: begin
                if (resp_ready) begin
                    resp_valid_d = 1'b0;
                    state_d      = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            op_a_q       <= '0;
            op_b_q       <= '0;
            last_grant_q <= IDW'(NREQ - 1);
            resp_id_q    <= '0;
            resp_sum_q   <= '0;
            resp_cout_q  <= 1'b0;
            resp_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            op_a_q       <= op_a_d;
            op_b_q       <= op_b_d;
            last_grant_q <= last_grant_d;
            resp_id_q    <= resp_id_d;
            resp_sum_q   <= resp_sum_d;
            resp_cout_q  <= resp_cout_d;
            resp_valid_q <= resp_valid_d;
        end
    end

    assign resp_valid = resp_valid_q;
    assign resp_id    = resp_id_q;
    assign resp_sum   = resp_sum_q;
    assign resp_cout  = resp_cout_q;
    assign busy       = (state_q != ST_IDLE);
endmodule

// File: tb/tb_adder_share_arbiter.sv
// tb/tb_adder_share_arbiter.sv - self-checking bench for adder_share_arbiter
module tb_adder_share_arbiter;
    localparam int NREQ = 4;
    localparam int W    = 32;
    localparam int ADD  = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ*W-1:0] req_a;
    logic [NREQ*W-1:0] req_b;
    logic [NREQ-1:0]   req_ready;
    logic              resp_valid;
    logic              resp_ready;
    logic [1:0]        resp_id;
    logic [W-1:0]      resp_sum;
    logic              resp_cout;
    logic              busy;

    int checks = 0;
    int errors = 0;

    // Transaction-level model state
    int          cyc = 0;
    bit          outstanding;
    int          m_last;
    int          m_id;
    int          m_acc;
    logic [32:0] m_sum;
    int          gnt_q[$];
    int          acc_q[$];

    adder_share_arbiter #(.NREQ(NREQ), .WIDTH(W), .ADD_CYCLES(ADD)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_ready  (req_ready),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_id    (resp_id),
        .resp_sum   (resp_sum),
        .resp_cout  (resp_cout),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          idx;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] sum;
        logic        cout;
    } vec_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int pick(input logic [NREQ-1:0] v, input int last);
        for (int off = 1; off <= NREQ; off++) begin
            if (v[(last + off) % NREQ]) return (last + off) % NREQ;
        end
        return -1;
    endfunction

    // Called at a negedge with inputs already driven; checks outputs against
    // the model, advances one clock, and leaves the bench at the next negedge.
    task automatic step();
        int              g;
        logic [NREQ-1:0] exp_rdy;
        bit              exp_rv;
        #1;
        g       = outstanding ? -1 : pick(req_valid, m_last);
        exp_rdy = (g < 0) ? '0 : NREQ'(1 << g);
        exp_rv  = outstanding && ((cyc - m_acc) >= ADD);
        chk("req_ready", 64'(req_ready), 64'(exp_rdy));
        chk("busy", 64'(busy), 64'(outstanding));
        chk("resp_valid", 64'(resp_valid), 64'(exp_rv));
        if (exp_rv) begin
            chk("resp_id", 64'(resp_id), 64'(m_id));
            chk("resp_sum", 64'({resp_cout, resp_sum}), 64'(m_sum));
        end
        @(posedge clk);
        cyc++;
        if (rst) begin
            outstanding = 0;
            m_last      = NREQ - 1;
        end else if (outstanding) begin
            if (exp_rv && resp_ready) outstanding = 0;
        end else if (g >= 0) begin
            outstanding = 1;
            m_last      = g;
            m_id        = g;
            m_sum       = {1'b0, req_a[g*W +: W]} + {1'b0, req_b[g*W +: W]};
            m_acc       = cyc;
            gnt_q.push_back(g);
            acc_q.push_back(cyc);
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    vec_t vecs[7];

    initial begin
        int          n0;
        logic [31:0] hs;
        logic [31:0] hid;
        logic        hc;
        vecs[0] = '{2, 32'h5555_5555, 32'hAAAA_AAAA, 32'hFFFF_FFFF, 1'b0};
        vecs[1] = '{0, 32'hD555_4554, 32'hAAAA_AAAA, 32'h7FFF_EFFE, 1'b1};
        vecs[2] = '{0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b1};
        vecs[3] = '{3, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 1'b0};
        vecs[4] = '{1, 32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1};
        vecs[5] = '{1, 32'h1234_5678, 32'h1111_1111, 32'h2345_6789, 1'b0};
        vecs[6] = '{3, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1'b0};

        rst        = 1'b1;
        req_valid  = '0;
        req_a      = '0;
        req_b      = '0;
        resp_ready = 1'b0;
        outstanding = 0;
        m_last      = NREQ - 1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        chk("rst_resp_valid", 64'(resp_valid), 64'd0);
        chk("rst_resp_sum", 64'(resp_sum), 64'd0);
        chk("rst_resp_cout", 64'(resp_cout), 64'd0);
        chk("rst_resp_id", 64'(resp_id), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        rst = 1'b0;
        @(negedge clk);

        // Table-driven single operations
        foreach (vecs[k]) begin
            req_valid = '0;
            req_valid[vecs[k].idx] = 1'b1;
            req_a[vecs[k].idx*W +: W] = vecs[k].a;
            req_b[vecs[k].idx*W +: W] = vecs[k].b;
            resp_ready = 1'b1;
            n0 = gnt_q.size();
            step();
            chk("vec_accepted", 64'(gnt_q.size()), 64'(n0 + 1));
            req_valid = '0;
            repeat (ADD) step();
            #1;
            chk("vec_valid", 64'(resp_valid), 64'd1);
            chk("vec_sum", 64'(resp_sum), 64'(vecs[k].sum));
            chk("vec_cout", 64'(resp_cout), 64'(vecs[k].cout));
            chk("vec_id", 64'(resp_id), 64'(vecs[k].idx));
            step();
            step();
            chk("vec_one_resp", 64'(resp_valid), 64'd0);
        end

        // Round robin with all requesters held
        do_reset();
        for (int i = 0; i < NREQ; i++) begin
            req_a[i*W +: W] = 32'h1000_0000 * (i + 1) + 32'h123;
            req_b[i*W +: W] = 32'h0F00_0000 + 32'h11 * i;
        end
        req_valid  = '1;
        resp_ready = 1'b1;
        gnt_q.delete();
        acc_q.delete();
        for (int t = 0; t < 60 && gnt_q.size() < 6; t++) step();
        chk("rr_count", 64'(gnt_q.size()), 64'd6);
        if (gnt_q.size() >= 6) begin
            for (int i = 0; i < 6; i++) chk("rr_order", 64'(gnt_q[i]), 64'(i % NREQ));
            for (int i = 1; i < 6; i++) chk("rr_gap", 64'(acc_q[i] - acc_q[i-1]), 64'(ADD + 2));
        end
        req_valid = '0;
        for (int t = 0; t < 10 && outstanding; t++) step();

        // Backpressure: hold the result 5 cycles with other requests pending
        req_valid  = 4'b0010;
        req_a[1*W +: W] = 32'hCAFE_0001;
        req_b[1*W +: W] = 32'h3501_FFFF;
        resp_ready = 1'b0;
        step();
        req_valid = 4'b1111;
        repeat (ADD) step();
        #1;
        hs  = resp_sum;
        hc  = resp_cout;
        hid = 32'(resp_id);
        chk("bp_valid", 64'(resp_valid), 64'd1);
        chk("bp_sum_const", 64'({resp_cout, resp_sum}), 64'h1_0000_0000);
        repeat (5) step();
        #1;
        chk("bp_hold_sum", 64'(resp_sum), 64'(hs));
        chk("bp_hold_cout", 64'(resp_cout), 64'(hc));
        chk("bp_hold_id", 64'(resp_id), 64'(hid));
        resp_ready = 1'b1;
        n0 = gnt_q.size();
        step();
        chk("bp_no_grant_in_hs", 64'(gnt_q.size()), 64'(n0));
        step();
        chk("bp_next_grant", 64'(gnt_q.size()), 64'(n0 + 1));
        req_valid = '0;
        for (int t = 0; t < 10 && outstanding; t++) step();

        // Reset during SETTLE: result dropped, priority restarts from requester 0
        req_valid = 4'b1010;
        step();
        step();
        chk("rm_granted", 64'(gnt_q[gnt_q.size()-1]), 64'd3);
        rst = 1'b1;
        step();
        rst = 1'b0;
        n0 = gnt_q.size();
        step();
        chk("rm_regrant", 64'(gnt_q.size()), 64'(n0 + 1));
        if (gnt_q.size() > n0) chk("rm_first_id", 64'(gnt_q[n0]), 64'd1);
        req_valid = '0;
        for (int t = 0; t < 10 && outstanding; t++) step();

        // Randomized traffic against the model
        for (int it = 0; it < 1000; it++) begin
            req_valid  = NREQ'($urandom_range(0, 15));
            resp_ready = ($urandom_range(0, 3) != 0);
            for (int i = 0; i < NREQ; i++) begin
                req_a[i*W +: W] = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF : $urandom;
                req_b[i*W +: W] = ($urandom_range(0, 7) == 0) ? 32'h0000_0001 : $urandom;
            end
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
